// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one slow-clocked UART transmitter between NUM_REQ byte sources.
// Multi-byte messages are locked to their owner; the load strobe is stretched for the slow domain.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int STROBE_CYCLES = 16384,
  parameter int BUSY_TIMEOUT  = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_byte,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   tx_din_rdy,
  output logic [7:0]             tx_din_byte,
  input  logic                   tx_uart_ready,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int CNT_MAX = (STROBE_CYCLES > BUSY_TIMEOUT) ? STROBE_CYCLES : BUSY_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT_BUSY,
    WAIT_READY
  } state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [PW-1:0]       ptr_reg, ptr_next;
  logic                lock_reg, lock_next;
  logic [NUM_REQ-1:0]  grant_reg, grant_next;
  logic [NUM_REQ-1:0]  ack_reg, ack_next;
  logic                rdy_out_reg, rdy_out_next;
  logic [7:0]          byte_reg, byte_next;
  logic                tout_reg, tout_next;
  logic                rdy_meta_reg, rdy_s_reg;

  logic [7:0]          req_byte_arr [NUM_REQ];
  logic                win_found;
  logic [PW-1:0]       win_idx;
  logic [PW-1:0]       cand;
  logic                load_en;
  logic [PW-1:0]       load_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_byte_split
      assign req_byte_arr[gi] = req_byte[8*gi +: 8];
    end
  endgenerate

  // tx_uart_ready lives in the slow domain; only the synchronized copy is ever used.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_meta_reg <= 1'b0;
      rdy_s_reg    <= 1'b0;
    end else begin
      rdy_meta_reg <= tx_uart_ready;
      rdy_s_reg    <= rdy_meta_reg;
    end
  end

  // Round-robin search starting just after the last owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((int'(ptr_reg) + k) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      ptr_reg     <= PW'(NUM_REQ - 1);
      lock_reg    <= 1'b0;
      grant_reg   <= '0;
      ack_reg     <= '0;
      rdy_out_reg <= 1'b0;
      byte_reg    <= '0;
      tout_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      ptr_reg     <= ptr_next;
      lock_reg    <= lock_next;
      grant_reg   <= grant_next;
      ack_reg     <= ack_next;
      rdy_out_reg <= rdy_out_next;
      byte_reg    <= byte_next;
      tout_reg    <= tout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    ptr_next     = ptr_reg;
    lock_next    = lock_reg;
    grant_next   = grant_reg;
    ack_next     = '0;
    rdy_out_next = rdy_out_reg;
    byte_next    = byte_reg;
    tout_next    = 1'b0;
    load_en      = 1'b0;
    load_idx     = win_idx;

    case (state_reg)
      IDLE: begin
        if (rdy_s_reg && win_found) begin
          load_en = 1'b1;
        end
      end
      STROBE: begin
        if (cnt_reg == '0) begin
          rdy_out_next = 1'b0;
          cnt_next     = CW'(BUSY_TIMEOUT - 1);
          state_next   = WAIT_BUSY;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      WAIT_BUSY: begin
        if (!rdy_s_reg) begin
          state_next = WAIT_READY;
        end else if (cnt_reg == '0) begin
          tout_next  = 1'b1;
          lock_next  = 1'b0;
          grant_next = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      WAIT_READY: begin
        // A locked owner keeps the transmitter; everyone else waits for IDLE.
        if (rdy_s_reg) begin
          if (lock_reg && req[ptr_reg]) begin
            load_en  = 1'b1;
            load_idx = ptr_reg;
          end else begin
            lock_next  = 1'b0;
            grant_next = '0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (load_en) begin
      grant_next   = ONE_HOT0 << load_idx;
      ack_next     = ONE_HOT0 << load_idx;
      ptr_next     = load_idx;
      byte_next    = req_byte_arr[load_idx];
      lock_next    = ~req_last[load_idx];
      rdy_out_next = 1'b1;
      cnt_next     = CW'(STROBE_CYCLES - 1);
      state_next   = STROBE;
    end
  end

  assign req_ack     = ack_reg;
  assign grant       = grant_reg;
  assign tx_din_rdy  = rdy_out_reg;
  assign tx_din_byte = byte_reg;
  assign busy        = (state_reg != IDLE);
  assign timeout_err = tout_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-driven requesters, a simple transmitter model,
// and a negedge monitor that logs loads, acks, grants and strobe lengths.
module tb_uart_tx_arbiter;

  typedef int iq_t[$];

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] req_byte;
  logic [1:0]  req_last;
  logic [1:0]  req_ack;
  logic [1:0]  grant;
  logic        tx_din_rdy;
  logic [7:0]  tx_din_byte;
  logic        tx_uart_ready;
  logic        busy;
  logic        timeout_err;

  uart_tx_arbiter #(
    .NUM_REQ(2),
    .STROBE_CYCLES(4),
    .BUSY_TIMEOUT(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_byte(req_byte),
    .req_last(req_last),
    .req_ack(req_ack),
    .grant(grant),
    .tx_din_rdy(tx_din_rdy),
    .tx_din_byte(tx_din_byte),
    .tx_uart_ready(tx_uart_ready),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  int checks;
  int failures;

  logic [8:0] rq0[$];
  logic [8:0] rq1[$];
  iq_t load_log, ack_log, len_log, grant_log, exp_q;

  int cyc, fall_cyc, tout_cyc, tout_cnt, run_len;
  int multi_ack, ack_misplaced, byte_glitch;
  logic prev_rdy, prev_busy;
  logic [1:0] prev_grant;
  logic [7:0] prev_byte;
  logic stuck, m_prev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_q(input string tag, input iq_t got, input iq_t exp);
    check({tag, "_len"}, got.size(), exp.size());
    foreach (exp[i]) check($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : -1, exp[i]);
  endtask

  task automatic clear_logs();
    load_log.delete();
    ack_log.delete();
    len_log.delete();
    grant_log.delete();
    tout_cnt = 0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n;
    n = 0;
    while ((busy || rq0.size() > 0 || rq1.size() > 0 || !tx_uart_ready) && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= maxc) check({tag, "_idle_timeout"}, 0, 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input string tag, input int cnt, input int maxc);
    int n;
    n = 0;
    while (ack_log.size() < cnt && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= maxc) check({tag, "_ack_timeout"}, 0, 1);
  endtask

  // Transmitter model: ready falls 3 clk after the strobe rises, returns 10 clk later.
  initial begin
    tx_uart_ready = 1'b1;
    m_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_din_rdy && !m_prev && !stuck) begin
        repeat (3) @(negedge clk);
        tx_uart_ready = 1'b0;
        repeat (10) @(negedge clk);
        tx_uart_ready = 1'b1;
      end
      m_prev = tx_din_rdy;
    end
  end

  // Monitor plus requester model; requesters pop their head byte on ack.
  initial begin
    logic [8:0] h0, h1;
    cyc = 0; run_len = 0; fall_cyc = 0; tout_cyc = 0; tout_cnt = 0;
    multi_ack = 0; ack_misplaced = 0; byte_glitch = 0;
    prev_rdy = 1'b0; prev_busy = 1'b0; prev_grant = 2'b00; prev_byte = 8'h00;
    req = 2'b00; req_byte = 16'h0; req_last = 2'b00;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if ($countones(req_ack) > 1) multi_ack++;
        if (req_ack != 2'b00 && !(tx_din_rdy && !prev_rdy)) ack_misplaced++;
        if (req_ack[0]) ack_log.push_back(0);
        if (req_ack[1]) ack_log.push_back(1);
        if (busy && prev_busy && req_ack == 2'b00 && tx_din_byte != prev_byte) byte_glitch++;
      end
      if (tx_din_rdy && !prev_rdy) begin
        load_log.push_back(int'(tx_din_byte));
        $display("load byte=%02h grant=%b ack=%b t=%0t", tx_din_byte, grant, req_ack, $time);
      end
      if (tx_din_rdy) run_len++;
      else if (prev_rdy) begin
        len_log.push_back(run_len);
        fall_cyc = cyc;
        run_len = 0;
      end
      if (timeout_err === 1'b1) begin
        tout_cnt++;
        tout_cyc = cyc;
      end
      if (grant !== prev_grant) grant_log.push_back(int'(grant));
      prev_rdy = tx_din_rdy; prev_busy = busy; prev_grant = grant; prev_byte = tx_din_byte;

      if (req_ack[0] === 1'b1 && rq0.size() > 0) rq0.delete(0);
      if (req_ack[1] === 1'b1 && rq1.size() > 0) rq1.delete(0);
      h0 = (rq0.size() > 0) ? rq0[0] : 9'h0;
      h1 = (rq1.size() > 0) ? rq1[0] : 9'h0;
      req      = {rq1.size() > 0, rq0.size() > 0};
      req_byte = {h1[7:0], h0[7:0]};
      req_last = {h1[8], h0[8]};
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks = 0; failures = 0;
    rst = 1'b1; stuck = 1'b0;

    // 1: reset with both requesters pending
    rq0.push_back({1'b1, 8'h5A});
    rq1.push_back({1'b1, 8'hC3});
    repeat (2) @(posedge clk);
    #1;
    check("t1_req_seen", req, 2'b11);
    check("t1_rdy", tx_din_rdy, 0);
    check("t1_grant", grant, 0);
    check("t1_ack", req_ack, 0);
    check("t1_busy", busy, 0);
    check("t1_tout", timeout_err, 0);
    check("t1_byte", tx_din_byte, 0);
    rq0.delete(); rq1.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t1_no_ack", ack_log.size(), 0);
    check("t1_idle", busy, 0);

    // 2: single byte, cycle-exact load
    clear_logs();
    rq0.push_back({1'b1, 8'hA5});
    @(posedge clk); #1;
    check("t2_ack", req_ack, 2'b01);
    check("t2_rdy", tx_din_rdy, 1);
    check("t2_byte", tx_din_byte, 8'hA5);
    check("t2_grant", grant, 2'b01);
    check("t2_busy", busy, 1);
    @(posedge clk); #1;
    check("t2_ack_pulse", req_ack, 2'b00);
    check("t2_rdy_hold", tx_din_rdy, 1);
    wait_idle("t2", 200);
    exp_q = '{4};
    compare_q("t2_strobe_len", len_log, exp_q);
    exp_q = '{1, 0};
    compare_q("t2_grants", grant_log, exp_q);
    check("t2_byte_stable", byte_glitch, 0);

    // 3: round-robin from reset pointer
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    clear_logs();
    rq0.push_back({1'b1, 8'h10}); rq0.push_back({1'b1, 8'h12});
    rq1.push_back({1'b1, 8'h11}); rq1.push_back({1'b1, 8'h13});
    wait_idle("t3", 400);
    exp_q = '{'h10, 'h11, 'h12, 'h13};
    compare_q("t3_loads", load_log, exp_q);
    exp_q = '{0, 1, 0, 1};
    compare_q("t3_acks", ack_log, exp_q);
    exp_q = '{4, 4, 4, 4};
    compare_q("t3_lens", len_log, exp_q);

    // 4: locked 3-byte message from requester 1 while requester 0 waits
    clear_logs();
    rq1.push_back({1'b0, 8'h11}); rq1.push_back({1'b0, 8'h22}); rq1.push_back({1'b1, 8'h33});
    wait_acks("t4", 1, 50);
    rq0.push_back({1'b1, 8'h44});
    wait_idle("t4", 400);
    exp_q = '{'h11, 'h22, 'h33, 'h44};
    compare_q("t4_loads", load_log, exp_q);
    exp_q = '{1, 1, 1, 0};
    compare_q("t4_acks", ack_log, exp_q);
    exp_q = '{2, 0, 1, 0};
    compare_q("t4_grants", grant_log, exp_q);

    // 5: locked owner abandons its message
    clear_logs();
    rq1.push_back({1'b0, 8'h55});
    wait_acks("t5", 1, 50);
    rq0.push_back({1'b1, 8'h66});
    wait_idle("t5", 300);
    exp_q = '{'h55, 'h66};
    compare_q("t5_loads", load_log, exp_q);
    exp_q = '{2, 0, 1, 0};
    compare_q("t5_grants", grant_log, exp_q);

    // 6: transmitter never goes busy
    clear_logs();
    stuck = 1'b1;
    rq0.push_back({1'b0, 8'h88});
    n = 0;
    while (timeout_err !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_tout_seen", timeout_err, 1);
    check("t6_busy", busy, 0);
    check("t6_grant", grant, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_tout_width", tout_cnt, 1);
    check("t6_tout_delay", tout_cyc - fall_cyc, 20);
    stuck = 1'b0;
    rq0.push_back({1'b1, 8'hAA});
    rq1.push_back({1'b1, 8'h99});
    wait_idle("t6", 300);
    exp_q = '{'h88, 'h99, 'hAA};
    compare_q("t6_loads", load_log, exp_q);
    exp_q = '{0, 1, 0};
    compare_q("t6_acks", ack_log, exp_q);

    // 7: reset during the strobe
    clear_logs();
    rq0.push_back({1'b1, 8'hBB});
    n = 0;
    while (tx_din_rdy !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("t7_strobe_seen", tx_din_rdy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t7_rdy", tx_din_rdy, 0);
    check("t7_grant", grant, 0);
    check("t7_busy", busy, 0);
    check("t7_ack", req_ack, 0);
    rst = 1'b0;
    wait_idle("t7", 200);
    exp_q = '{'hBB};
    compare_q("t7_loads", load_log, exp_q);
    exp_q = '{0};
    compare_q("t7_acks", ack_log, exp_q);
    exp_q = '{2};
    compare_q("t7_lens", len_log, exp_q);

    check("multi_ack", multi_ack, 0);
    check("ack_outside_load", ack_misplaced, 0);
    check("byte_stable_all", byte_glitch, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
